// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//    Shares the register file's single write port between the ALU/immediate
//    path and the load/store unit. One request is granted per cycle. It is
//    registered and then drives RUWr/rd/DataWr for exactly one cycle. A
//    starvation counter stops a continuous stream of load returns from
//    locking out the ALU.
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    alu_valid/rd/data   ALU write-back request
//    alu_ready           ALU request accepted this cycle (combinational)
//    mem_valid/rd/data   load write-back request
//    mem_ready           load request accepted this cycle (combinational)
//    RUWr, rd, DataWr    register-file write port (registered)
//    wb_src              source of the current write: 0 = ALU, 1 = mem
//    starve_cnt          consecutive contested cycles the ALU has lost
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int REGW       = 5,
   parameter int STARVE_MAX = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [REGW-1:0] alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [REGW-1:0] mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic            RUWr,
   output logic [REGW-1:0] rd,
   output logic [XLEN-1:0] DataWr,
   output logic            wb_src,
   output logic [3:0]      starve_cnt
);

   typedef enum logic {
      PRI_MEM = 1'b0,
      PRI_ALU = 1'b1
   } state_t;

   localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            ruwr_q, ruwr_d;
   logic [REGW-1:0] rd_q, rd_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            src_q, src_d;

   logic            grant_alu;
   logic            grant_mem;
   logic            contested;
   logic [4:0]      cnt_inc;

   // State and write-port registers. Reset also clears an in-flight write,
   // so RUWr falls immediately when rst_n is pulled low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PRI_MEM;
         cnt_q   <= 4'd0;
         ruwr_q  <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ruwr_q  <= ruwr_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ruwr_d    = 1'b0;
      rd_d      = rd_q;
      data_d    = data_q;
      src_d     = src_q;

      contested = alu_valid && mem_valid;
      // The priority state only matters when both sides are asking.
      grant_alu = alu_valid && (!mem_valid || (state_q == PRI_ALU));
      grant_mem = mem_valid && (!alu_valid || (state_q == PRI_MEM));
      // Widened so the compare against STARVE_MAX cannot wrap at 15.
      cnt_inc   = {1'b0, cnt_q} + 5'd1;

      // Starvation count: only a contested loss by the ALU counts.
      if (grant_alu) begin
         cnt_d = 4'd0;
      end else if (contested && grant_mem && (cnt_q != 4'hF)) begin
         cnt_d = cnt_q + 4'd1;
      end

      unique case (state_q)
         PRI_MEM: begin
            // Flip priority on the loss that reaches the limit, so the
            // ALU wins the very next contested cycle.
            if (contested && grant_mem && (cnt_inc == STARVE_LIM)) begin
               state_d = PRI_ALU;
            end
         end
         PRI_ALU: begin
            if (grant_alu) begin
               state_d = PRI_MEM;
            end
         end
         default: state_d = PRI_MEM;
      endcase

      // Writes to x0 still complete the handshake and load rd/DataWr,
      // but never raise the write enable.
      if (grant_alu) begin
         ruwr_d = (alu_rd != '0);
         rd_d   = alu_rd;
         data_d = alu_data;
         src_d  = 1'b0;
      end else if (grant_mem) begin
         ruwr_d = (mem_rd != '0);
         rd_d   = mem_rd;
         data_d = mem_data;
         src_d  = 1'b1;
      end
   end

   assign alu_ready  = grant_alu;
   assign mem_ready  = grant_mem;
   assign RUWr       = ruwr_q;
   assign rd         = rd_q;
   assign DataWr     = data_q;
   assign wb_src     = src_q;
   assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Driver applies one request pair per cycle, checks the combinational
// readies against a reference model and queues the write-port state the
// model expects after the edge. A separate monitor pops that queue after
// each rising edge and compares the registered outputs.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   localparam int XLEN = 32;
   localparam int REGW = 5;
   localparam int SMAX = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_valid = 1'b0;
   logic [REGW-1:0] alu_rd = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic            alu_ready;
   logic            mem_valid = 1'b0;
   logic [REGW-1:0] mem_rd = '0;
   logic [XLEN-1:0] mem_data = '0;
   logic            mem_ready;
   logic            RUWr;
   logic [REGW-1:0] rd;
   logic [XLEN-1:0] DataWr;
   logic            wb_src;
   logic [3:0]      starve_cnt;

   rf_wb_arbiter #(.XLEN(XLEN), .REGW(REGW), .STARVE_MAX(SMAX)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .mem_valid  (mem_valid),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_ready  (mem_ready),
      .RUWr       (RUWr),
      .rd         (rd),
      .DataWr     (DataWr),
      .wb_src     (wb_src),
      .starve_cnt (starve_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            ruwr;
      logic [REGW-1:0] rd;
      logic [XLEN-1:0] data;
      logic            src;
      logic [3:0]      cnt;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   // Reference model: the ALU wins a contested cycle only once it has lost
   // SMAX contested cycles since its last grant.
   int              m_losses;
   logic [REGW-1:0] m_rd;
   logic [XLEN-1:0] m_data;
   logic            m_src;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_losses = 0;
      m_rd     = '0;
      m_data   = '0;
      m_src    = 1'b0;
   endtask

   // Called at posedge+1. Drives, checks readies mid-cycle, queues the
   // expected post-edge state, and returns at the next posedge+1.
   task automatic cycle(input bit av, input logic [REGW-1:0] ard, input logic [XLEN-1:0] ad,
                        input bit mv, input logic [REGW-1:0] mrd, input logic [XLEN-1:0] md,
                        output bit ga, output bit gm);
      exp_t e;
      bit   forced;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      @(negedge clk);
      forced = (m_losses >= SMAX);
      ga = av && (!mv || forced);
      gm = mv && !ga;
      chk("alu_ready", 32'(alu_ready), 32'(ga));
      chk("mem_ready", 32'(mem_ready), 32'(gm));
      if (ga) m_losses = 0;
      else if (av && mv) m_losses = (m_losses + 1 > 15) ? 15 : m_losses + 1;
      if (ga) begin m_rd = ard; m_data = ad; m_src = 1'b0; end
      else if (gm) begin m_rd = mrd; m_data = md; m_src = 1'b1; end
      e.ruwr = (ga || gm) && (m_rd != '0);
      e.rd   = m_rd;
      e.data = m_data;
      e.src  = m_src;
      e.cnt  = 4'(m_losses);
      sb.push_back(e);
      $display("txn av=%0b ard=%0d ad=%08h mv=%0b mrd=%0d md=%08h -> ga=%0b gm=%0b cnt=%0d",
               av, ard, ad, mv, mrd, md, ga, gm, m_losses);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bit ga, gm;
      cycle(1'b0, '0, '0, 1'b0, '0, '0, ga, gm);
   endtask

   // Monitor: compare registered outputs after every edge that has a
   // queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("RUWr",       32'(RUWr),       32'(e.ruwr));
            chk("rd",         32'(rd),         32'(e.rd));
            chk("DataWr",     DataWr,          e.data);
            chk("wb_src",     32'(wb_src),     32'(e.src));
            chk("starve_cnt", 32'(starve_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      bit ga, gm;
      bit pa, pm;
      logic [REGW-1:0] pa_rd, pm_rd;
      logic [XLEN-1:0] pa_d, pm_d;
      bit exp_alu_pat;
      int wait_cnt;

      model_reset();

      // Reset held with both requesters asking.
      rst_n = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
      alu_rd = 5'd7; mem_rd = 5'd9; alu_data = 32'h1111; mem_data = 32'h2222;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_RUWr",   32'(RUWr),       32'd0);
      chk("rst_rd",     32'(rd),         32'd0);
      chk("rst_DataWr", DataWr,          32'd0);
      chk("rst_wb_src", 32'(wb_src),     32'd0);
      chk("rst_cnt",    32'(starve_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention: mem wins three, ALU wins the fourth, repeating.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 5'(i + 1), 32'(32'hA000 + i), 1'b1, 5'(i + 11), 32'(32'hB000 + i), ga, gm);
         exp_alu_pat = ((i % 4) == 3);
         chk("contend_alu_grant", 32'(ga), 32'(exp_alu_pat));
      end

      idle();
      cycle(1'b1, 5'd5, 32'h0000_0068, 1'b0, '0, '0, ga, gm);
      idle();

      // x0 load: handshake completes, no write enable.
      cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF, ga, gm);
      idle();

      // Held mem stream with no ALU traffic.
      for (int i = 0; i < 4; i++)
         cycle(1'b0, '0, '0, 1'b1, 5'(20 + i), 32'(32'hC000 + i), ga, gm);
      idle();

      // Reset while a write is on the port.
      cycle(1'b1, 5'd2, 32'd1024, 1'b0, '0, '0, ga, gm);
      alu_valid = 1'b0;
      chk("midrst_RUWr_before", 32'(RUWr), 32'd1);
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("midrst_RUWr",   32'(RUWr),   32'd0);
      chk("midrst_rd",     32'(rd),     32'd0);
      chk("midrst_DataWr", DataWr,      32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomised traffic; each requester holds its request until granted.
      pa = 1'b0; pm = 1'b0;
      pa_rd = '0; pm_rd = '0; pa_d = '0; pm_d = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!pa && ($urandom_range(3) != 0)) begin
            pa = 1'b1;
            pa_rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            pa_d = $urandom;
         end
         if (!pm && ($urandom_range(3) != 0)) begin
            pm = 1'b1;
            pm_rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            pm_d = $urandom;
         end
         cycle(pa, pa_rd, pa_d, pm, pm_rd, pm_d, ga, gm);
         if (ga) pa = 1'b0;
         if (gm) pm = 1'b0;
      end

      idle();
      alu_valid = 1'b0; mem_valid = 1'b0;
      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      #5;
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d pending required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
